// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Instruction-type encodings match the core decoder; INSTTYPE_HALT added for HLT.
package hazard_ctrl_pipe_pkg;

    // Instruction class reported by the decoder for the instruction in ID
    localparam logic [2:0] INSTTYPE_ALU    = 3'd0;
    localparam logic [2:0] INSTTYPE_LOAD   = 3'd1;
    localparam logic [2:0] INSTTYPE_STORE  = 3'd2;
    localparam logic [2:0] INSTTYPE_BRANCH = 3'd3;
    localparam logic [2:0] INSTTYPE_JUMP   = 3'd4;
    localparam logic [2:0] INSTTYPE_HALT   = 3'd5;

    // Widths of the two penalty windows
    localparam int FLUSH_CNT_W = 3;   // covers JUMP_PEN / BR_PEN up to 7
    localparam int MC_CNT_W    = 4;   // covers MC_LAT up to 15

    // Winning event of the per-cycle priority chain, highest first
    typedef enum logic [2:0] {
        EV_HALTED   = 3'd0,
        EV_BRANCH   = 3'd1,
        EV_MULTI    = 3'd2,
        EV_FLUSH    = 3'd3,
        EV_LOAD_USE = 3'd4,
        EV_JUMP     = 3'd5,
        EV_NONE     = 3'd6
    } hz_event_e;

    // Only the quiet path and a jump let the ID instruction retire;
    // every other event either stalls it or squashes it.
    function automatic logic event_retires(hz_event_e ev);
        return (ev == EV_NONE) || (ev == EV_JUMP);
    endfunction

endpackage

// File: rtl/hazard_penalty_cnt.sv
// Loadable down-counter used for the flush and multi-cycle penalty windows.
// busy is high while the remaining count is non-zero.
module hazard_penalty_cnt
    import hazard_ctrl_pipe_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         busy
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next count: clear beats load beats decrement; decrement saturates at zero
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_val;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign busy  = (value_q != '0);

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Pipeline hazard controller for the 5-stage TSC core.
// Stalls on load-use and multi-cycle EX ops, opens flush windows for jumps
// (resolved in ID) and taken branches (resolved in EX), counts retired
// instructions and latches HLT.
module hazard_ctrl_pipe
    import hazard_ctrl_pipe_pkg::*;
#(
    parameter int REG_AW   = 2,
    parameter int JUMP_PEN = 1,
    parameter int BR_PEN   = 2,
    parameter int MC_LAT   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        inst_type_id,
    input  logic              valid_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              valid_ex,
    input  logic              mem_read_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mc_start_ex,
    input  logic              br_taken_ex,
    input  logic              halt_id,
    output logic              pc_write,
    output logic              ir_write,
    output logic              bubblify,
    output logic              flush,
    output logic              incr_num_inst,
    output logic [CNT_W-1:0]  num_inst,
    output logic              halted
);

    // The window counters hold "cycles remaining after this one", so the
    // triggering cycle itself is the first penalty cycle.
    localparam logic [FLUSH_CNT_W-1:0] JUMP_LOAD = FLUSH_CNT_W'(JUMP_PEN - 1);
    localparam logic [FLUSH_CNT_W-1:0] BR_LOAD   = FLUSH_CNT_W'(BR_PEN - 1);
    localparam logic [MC_CNT_W-1:0]    MC_LOAD   = MC_CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);

    hz_event_e ev;

    logic load_use;
    logic jump_id;

    logic                   fl_load;
    logic                   fl_dec;
    logic [FLUSH_CNT_W-1:0] fl_value;
    logic                   fl_busy;

    logic                   mc_clr;
    logic                   mc_load;
    logic                   mc_dec;
    logic [MC_CNT_W-1:0]    mc_value;
    logic                   mc_busy;

    logic                   halted_q;
    logic                   halted_d;
    logic [CNT_W-1:0]       num_inst_q;
    logic [CNT_W-1:0]       num_inst_d;

    // Load-use: EX load writes a register the ID instruction is about to read
    always_comb begin
        load_use = valid_ex && mem_read_ex && valid_id &&
                   ((use_rs1_id && (rs1_id == rd_ex)) ||
                    (use_rs2_id && (rs2_id == rd_ex)));
        jump_id  = valid_id && (inst_type_id == INSTTYPE_JUMP);
    end

    // Priority chain picks the single event that governs this cycle
    always_comb begin
        ev = EV_NONE;
        if (halted_q) begin
            ev = EV_HALTED;
        end else if (br_taken_ex) begin
            ev = EV_BRANCH;
        end else if (mc_busy || mc_start_ex) begin
            ev = EV_MULTI;
        end else if (fl_busy) begin
            ev = EV_FLUSH;
        end else if (load_use) begin
            ev = EV_LOAD_USE;
        end else if (jump_id) begin
            ev = EV_JUMP;
        end
    end

    // Pipeline control outputs and window-counter commands for the chosen event
    always_comb begin
        pc_write      = 1'b1;
        ir_write      = 1'b1;
        bubblify      = 1'b0;
        flush         = 1'b0;
        incr_num_inst = 1'b0;
        fl_load       = 1'b0;
        fl_dec        = 1'b0;
        mc_clr        = 1'b0;
        mc_load       = 1'b0;
        mc_dec        = 1'b0;

        unique case (ev)
            EV_HALTED: begin
                pc_write = 1'b0;
                ir_write = 1'b0;
                bubblify = 1'b1;
            end
            EV_BRANCH: begin
                // Wrong-path fetch/decode slots are squashed; any pending
                // multi-cycle window belongs to the wrong path as well.
                flush    = 1'b1;
                bubblify = 1'b1;
                fl_load  = 1'b1;
                mc_clr   = 1'b1;
            end
            EV_MULTI: begin
                pc_write = 1'b0;
                ir_write = 1'b0;
                bubblify = 1'b1;
                mc_load  = mc_start_ex;
                mc_dec   = !mc_start_ex;
            end
            EV_FLUSH: begin
                flush    = 1'b1;
                bubblify = 1'b1;
                fl_dec   = 1'b1;
            end
            EV_LOAD_USE: begin
                // One bubble is enough: the load moves to MEM and forwarding covers the rest
                pc_write = 1'b0;
                ir_write = 1'b0;
                bubblify = 1'b1;
            end
            EV_JUMP: begin
                // The jump proceeds; only the slot fetched behind it is squashed
                flush   = 1'b1;
                fl_load = 1'b1;
            end
            default: begin
            end
        endcase

        incr_num_inst = valid_id && event_retires(ev);

        // Hold the pipeline in its idle configuration while reset is asserted
        if (!reset_n) begin
            pc_write      = 1'b1;
            ir_write      = 1'b1;
            bubblify      = 1'b0;
            flush         = 1'b0;
            incr_num_inst = 1'b0;
            fl_load       = 1'b0;
            fl_dec        = 1'b0;
            mc_clr        = 1'b0;
            mc_load       = 1'b0;
            mc_dec        = 1'b0;
        end
    end

    // Flush window: loaded by jumps and taken branches
    hazard_penalty_cnt #(
        .W (FLUSH_CNT_W)
    ) u_flush_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (1'b0),
        .load     (fl_load),
        .load_val ((ev == EV_BRANCH) ? BR_LOAD : JUMP_LOAD),
        .dec      (fl_dec),
        .value    (fl_value),
        .busy     (fl_busy)
    );

    // Multi-cycle window: loaded by the EX start pulse, cancelled by a taken branch
    hazard_penalty_cnt #(
        .W (MC_CNT_W)
    ) u_mc_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (mc_clr),
        .load     (mc_load),
        .load_val (MC_LOAD),
        .dec      (mc_dec),
        .value    (mc_value),
        .busy     (mc_busy)
    );

    // Retire counter and halt latch next-state; HLT stops the core once it retires
    always_comb begin
        num_inst_d = num_inst_q;
        halted_d   = halted_q;
        if (incr_num_inst) begin
            num_inst_d = num_inst_q + CNT_ONE;
            if (halt_id) begin
                halted_d = 1'b1;
            end
        end
    end

    // Retire counter and halt latch registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            num_inst_q <= num_inst_d;
            halted_q   <= halted_d;
        end
    end

    assign num_inst = num_inst_q;
    assign halted   = halted_q;

    // A multi-cycle op cannot start in the same EX slot as a resolving branch
    a_no_mc_with_branch : assert property (
        @(posedge clk) disable iff (!reset_n) !(mc_start_ex && br_taken_ex)
    );

    // The window counters never hold a value larger than their load values
    a_flush_bounded : assert property (
        @(posedge clk) disable iff (!reset_n)
        (fl_value <= BR_LOAD) || (fl_value <= JUMP_LOAD)
    );

    a_mc_bounded : assert property (
        @(posedge clk) disable iff (!reset_n) mc_value <= MC_LOAD
    );

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe. Two instances share all stimulus:
// dut_a uses JUMP_PEN=1 / CNT_W=16, dut_b uses JUMP_PEN=3 / CNT_W=4.
// Control outputs are compared as {pc_write, ir_write, bubblify, flush, incr_num_inst}.
module tb_hazard_ctrl_pipe;
    import hazard_ctrl_pipe_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [2:0] inst_type_id;
    logic       valid_id;
    logic       use_rs1_id;
    logic       use_rs2_id;
    logic [1:0] rs1_id;
    logic [1:0] rs2_id;
    logic       valid_ex;
    logic       mem_read_ex;
    logic [1:0] rd_ex;
    logic       mc_start_ex;
    logic       br_taken_ex;
    logic       halt_id;

    logic        a_pc_write, a_ir_write, a_bubblify, a_flush, a_incr, a_halted;
    logic [15:0] a_num_inst;
    logic        b_pc_write, b_ir_write, b_bubblify, b_flush, b_incr, b_halted;
    logic [3:0]  b_num_inst;

    wire [4:0] a_ctl = {a_pc_write, a_ir_write, a_bubblify, a_flush, a_incr};
    wire [4:0] b_ctl = {b_pc_write, b_ir_write, b_bubblify, b_flush, b_incr};

    int checks = 0;
    int errors = 0;

    hazard_ctrl_pipe #(
        .REG_AW(2), .JUMP_PEN(1), .BR_PEN(2), .MC_LAT(4), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .inst_type_id(inst_type_id), .valid_id(valid_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .valid_ex(valid_ex), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
        .mc_start_ex(mc_start_ex), .br_taken_ex(br_taken_ex), .halt_id(halt_id),
        .pc_write(a_pc_write), .ir_write(a_ir_write), .bubblify(a_bubblify), .flush(a_flush),
        .incr_num_inst(a_incr), .num_inst(a_num_inst), .halted(a_halted)
    );

    hazard_ctrl_pipe #(
        .REG_AW(2), .JUMP_PEN(3), .BR_PEN(2), .MC_LAT(4), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .inst_type_id(inst_type_id), .valid_id(valid_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .valid_ex(valid_ex), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
        .mc_start_ex(mc_start_ex), .br_taken_ex(br_taken_ex), .halt_id(halt_id),
        .pc_write(b_pc_write), .ir_write(b_ir_write), .bubblify(b_bubblify), .flush(b_flush),
        .incr_num_inst(b_incr), .num_inst(b_num_inst), .halted(b_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        inst_type_id = INSTTYPE_ALU;
        valid_id     = 1'b0;
        use_rs1_id   = 1'b0;
        use_rs2_id   = 1'b0;
        rs1_id       = 2'd0;
        rs2_id       = 2'd0;
        valid_ex     = 1'b0;
        mem_read_ex  = 1'b0;
        rd_ex        = 2'd0;
        mc_start_ex  = 1'b0;
        br_taken_ex  = 1'b0;
        halt_id      = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    // Reset asserted in the middle of dut_b's 3-cycle jump flush window
    task automatic test_reset();
        do_reset();
        valid_id = 1'b1; inst_type_id = INSTTYPE_JUMP;
        @(negedge clk);
        checks++;
        if (b_ctl !== 5'b11011) begin errors++; $display("FAIL rst_pre_jump: got %b want %b", b_ctl, 5'b11011); end
        next_cycle();
        reset_n = 1'b0;   // jump still presented in ID while reset is held
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (b_ctl !== 5'b11000) begin errors++; $display("FAIL rst_hold_ctl[%0d]: got %b want %b", i, b_ctl, 5'b11000); end
            checks++;
            if (b_num_inst !== 4'd0 || a_num_inst !== 16'd0) begin
                errors++; $display("FAIL rst_hold_cnt[%0d]: got a=%0d b=%0d want 0", i, a_num_inst, b_num_inst);
            end
            checks++;
            if (b_halted !== 1'b0) begin errors++; $display("FAIL rst_hold_halted[%0d]: got %b want 0", i, b_halted); end
            next_cycle();
        end
        reset_n = 1'b1;
        set_idle();
        @(negedge clk);
        checks++;
        if (b_ctl !== 5'b11000 || a_ctl !== 5'b11000) begin
            errors++; $display("FAIL rst_release_ctl: got a=%b b=%b want 11000", a_ctl, b_ctl);
        end
        next_cycle();
    endtask

    // Jump in ID: dut_a squashes 1 slot, dut_b squashes 3 slots
    task automatic test_jump();
        logic [4:0] exp_a [4];
        logic [4:0] exp_b [4];
        exp_a[0] = 5'b11011; exp_b[0] = 5'b11011;   // jump cycle: flush and count
        exp_a[1] = 5'b11001; exp_b[1] = 5'b11110;
        exp_a[2] = 5'b11001; exp_b[2] = 5'b11110;
        exp_a[3] = 5'b11001; exp_b[3] = 5'b11001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid_id     = 1'b1;
            inst_type_id = (i == 0) ? INSTTYPE_JUMP : INSTTYPE_ALU;
            @(negedge clk);
            checks++;
            if (a_ctl !== exp_a[i]) begin errors++; $display("FAIL jump_a[%0d]: got %b want %b", i, a_ctl, exp_a[i]); end
            checks++;
            if (b_ctl !== exp_b[i]) begin errors++; $display("FAIL jump_b[%0d]: got %b want %b", i, b_ctl, exp_b[i]); end
            next_cycle();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (a_num_inst !== 16'd4 || b_num_inst !== 4'd2) begin
            errors++; $display("FAIL jump_count: got a=%0d b=%0d want a=4 b=2", a_num_inst, b_num_inst);
        end
        next_cycle();
    endtask

    // Load-use stall on rs1 and rs2, and non-matching cases
    task automatic test_load_use();
        // {valid_ex, mem_read_ex, rd_ex, use_rs1, rs1, use_rs2, rs2, expected ctl}
        logic       v_ex [5];
        logic [1:0] v_rd [5];
        logic       v_u1 [5];
        logic [1:0] v_r1 [5];
        logic       v_u2 [5];
        logic [1:0] v_r2 [5];
        logic [4:0] v_ctl[5];
        v_ex[0]=1; v_rd[0]=2; v_u1[0]=1; v_r1[0]=2; v_u2[0]=1; v_r2[0]=0; v_ctl[0]=5'b00100; // rs1 hit
        v_ex[1]=0; v_rd[1]=2; v_u1[1]=1; v_r1[1]=2; v_u2[1]=1; v_r2[1]=0; v_ctl[1]=5'b11001; // load advanced
        v_ex[2]=1; v_rd[2]=2; v_u1[2]=1; v_r1[2]=1; v_u2[2]=0; v_r2[2]=0; v_ctl[2]=5'b11001; // other reg
        v_ex[3]=1; v_rd[3]=2; v_u1[3]=0; v_r1[3]=2; v_u2[3]=1; v_r2[3]=3; v_ctl[3]=5'b11001; // rs1 unused
        v_ex[4]=1; v_rd[4]=2; v_u1[4]=0; v_r1[4]=0; v_u2[4]=1; v_r2[4]=2; v_ctl[4]=5'b00100; // rs2 hit
        do_reset();
        for (int i = 0; i < 5; i++) begin
            valid_id    = 1'b1;
            valid_ex    = v_ex[i];
            mem_read_ex = 1'b1;
            rd_ex       = v_rd[i];
            use_rs1_id  = v_u1[i];
            rs1_id      = v_r1[i];
            use_rs2_id  = v_u2[i];
            rs2_id      = v_r2[i];
            @(negedge clk);
            checks++;
            if (a_ctl !== v_ctl[i]) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, a_ctl, v_ctl[i]); end
            next_cycle();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (a_num_inst !== 16'd3) begin errors++; $display("FAIL load_use_count: got %0d want 3", a_num_inst); end
        next_cycle();
    endtask

    // Multi-cycle EX op stalls for MC_LAT=4 cycles including the start cycle
    task automatic test_multicycle();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            valid_id    = 1'b1;
            mc_start_ex = (i == 0);
            @(negedge clk);
            checks++;
            if (i < 4) begin
                if (a_ctl !== 5'b00100) begin errors++; $display("FAIL mc_stall[%0d]: got %b want %b", i, a_ctl, 5'b00100); end
            end else begin
                if (a_ctl !== 5'b11001) begin errors++; $display("FAIL mc_resume[%0d]: got %b want %b", i, a_ctl, 5'b11001); end
            end
            next_cycle();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (a_num_inst !== 16'd2) begin errors++; $display("FAIL mc_count: got %0d want 2", a_num_inst); end
        next_cycle();
    endtask

    // Taken branch together with a jump in ID: branch wins, BR_PEN=2 flush cycles
    task automatic test_branch_vs_jump();
        logic [4:0] exp_ctl [3];
        exp_ctl[0] = 5'b11110;
        exp_ctl[1] = 5'b11110;
        exp_ctl[2] = 5'b11001;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid_id     = 1'b1;
            inst_type_id = (i < 2) ? INSTTYPE_JUMP : INSTTYPE_ALU;
            br_taken_ex  = (i == 0);
            @(negedge clk);
            checks++;
            if (a_ctl !== exp_ctl[i]) begin errors++; $display("FAIL br_jump_a[%0d]: got %b want %b", i, a_ctl, exp_ctl[i]); end
            checks++;
            if (b_ctl !== exp_ctl[i]) begin errors++; $display("FAIL br_jump_b[%0d]: got %b want %b", i, b_ctl, exp_ctl[i]); end
            next_cycle();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (a_num_inst !== 16'd1 || b_num_inst !== 4'd1) begin
            errors++; $display("FAIL br_jump_count: got a=%0d b=%0d want 1", a_num_inst, b_num_inst);
        end
        next_cycle();
    endtask

    // 15 retirements then HLT: dut_b's 4-bit counter wraps to 0, both halt and freeze
    task automatic test_halt_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            valid_id = 1'b1;
            @(negedge clk);
            if (i == 0 || i == 14) begin
                checks++;
                if (b_ctl !== 5'b11001) begin errors++; $display("FAIL halt_fill[%0d]: got %b want %b", i, b_ctl, 5'b11001); end
            end
            next_cycle();
        end
        valid_id = 1'b1; inst_type_id = INSTTYPE_HALT; halt_id = 1'b1;
        @(negedge clk);
        checks++;
        if (b_num_inst !== 4'd15) begin errors++; $display("FAIL halt_pre_count: got %0d want 15", b_num_inst); end
        checks++;
        if (b_ctl !== 5'b11001 || b_halted !== 1'b0) begin
            errors++; $display("FAIL halt_retire: got ctl=%b halted=%b want 11001/0", b_ctl, b_halted);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            valid_id     = 1'b1;
            inst_type_id = (i == 1) ? INSTTYPE_JUMP : INSTTYPE_ALU;
            br_taken_ex  = (i == 0);
            @(negedge clk);
            checks++;
            if (b_ctl !== 5'b00100 || a_ctl !== 5'b00100) begin
                errors++; $display("FAIL halt_frozen_ctl[%0d]: got a=%b b=%b want 00100", i, a_ctl, b_ctl);
            end
            checks++;
            if (b_num_inst !== 4'd0 || a_num_inst !== 16'd16) begin
                errors++; $display("FAIL halt_frozen_cnt[%0d]: got a=%0d b=%0d want a=16 b=0", i, a_num_inst, b_num_inst);
            end
            checks++;
            if (a_halted !== 1'b1 || b_halted !== 1'b1) begin
                errors++; $display("FAIL halt_sticky[%0d]: got a=%b b=%b want 1", i, a_halted, b_halted);
            end
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        test_reset();
        test_jump();
        test_load_use();
        test_multicycle();
        test_branch_vs_jump();
        test_halt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
